// File: rtl/screen_seq_pkg.sv
// Shared types, default sizes and wrap-around index helpers for the screen sequencer.
package screen_seq_pkg;

    localparam int NUM_SCREENS_DEF = 10;
    localparam int SCREEN_W_DEF    = 4;
    localparam int AUTO_FRAMES_DEF = 180;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_LOAD    = 2'd2
    } state_e;

    // Next index in 0..n-1, wrapping the last index back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

    // Previous index in 0..n-1, wrapping 0 back to the last index.
    function automatic int unsigned wrap_dec(input int unsigned idx, input int unsigned n);
        return (idx == 32'd0) ? n - 32'd1 : idx - 32'd1;
    endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Modulo-PERIOD counter of frame_start pulses; emits a one-cycle tick on the
// frame_start that closes each period. Used for autoplay stepping.
module frame_tick_counter #(
    parameter int PERIOD = 180
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic frame_start_i,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear wins over counting so a user step never coincides with a tick.
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (frame_start_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/screen_sequencer.sv
// Screen sequencer: picks a target screen (switches or step register) and
// commits it to frame_writer only at a frame boundary via a req/ack load.
// Optional feature macro: SCREEN_AUTOPLAY_EN (timed auto-advance in step mode).
module screen_sequencer
    import screen_seq_pkg::*;
#(
    parameter int NUM_SCREENS = NUM_SCREENS_DEF,
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int AUTO_FRAMES = AUTO_FRAMES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                direct_mode,
    input  logic [SCREEN_W-1:0] sw_screen,
    input  logic                next_pulse,
    input  logic                prev_pulse,
    input  logic                autoplay,
    input  logic                frame_start,
    input  logic                load_ack,
    output logic                load_req,
    output logic [SCREEN_W-1:0] load_screen,
    output logic [SCREEN_W-1:0] screen,
    output logic                busy
);

    localparam logic [SCREEN_W-1:0] LAST = SCREEN_W'(NUM_SCREENS - 1);

    state_e              state_q, state_d;
    logic [SCREEN_W-1:0] step_q, step_d;
    logic [SCREEN_W-1:0] screen_q, screen_d;
    logic [SCREEN_W-1:0] load_screen_q, load_screen_d;
    logic                load_req_q, load_req_d;
    logic [SCREEN_W-1:0] target;
    logic                auto_step;

`ifdef SCREEN_AUTOPLAY_EN
    frame_tick_counter #(.PERIOD(AUTO_FRAMES)) u_frame_tick (
        .clk_i         (clk),
        .rst_ni        (rst),
        .frame_start_i (frame_start),
        .enable_i      (autoplay & ~direct_mode),
        .clear_i       (next_pulse | prev_pulse),
        .tick_o        (auto_step)
    );
`else
    localparam int unused_auto_frames = AUTO_FRAMES;
    logic unused_autoplay;
    assign unused_autoplay = autoplay;
    assign auto_step       = 1'b0;
`endif

    // Step register: user pulses in step mode, simultaneous pulses cancel.
    always_comb begin
        step_d = step_q;
        if (!direct_mode) begin
            if (next_pulse && !prev_pulse)
                step_d = SCREEN_W'(wrap_inc(32'(step_q), 32'(NUM_SCREENS)));
            else if (prev_pulse && !next_pulse)
                step_d = SCREEN_W'(wrap_dec(32'(step_q), 32'(NUM_SCREENS)));
            else if (auto_step)
                step_d = SCREEN_W'(wrap_inc(32'(step_q), 32'(NUM_SCREENS)));
        end
    end

    // Target mux; switch values beyond the last screen clamp to it.
    always_comb begin
        target = step_q;
        if (direct_mode) target = (sw_screen > LAST) ? LAST : sw_screen;
    end

    // FSM next state: wait for a frame boundary, then hold the offer until ack.
    always_comb begin
        state_d       = state_q;
        screen_d      = screen_q;
        load_screen_d = load_screen_q;
        load_req_d    = load_req_q;
        unique case (state_q)
            S_IDLE: begin
                if (target != screen_q) state_d = S_PENDING;
            end
            S_PENDING: begin
                if (target == screen_q) begin
                    state_d = S_IDLE;
                end else if (frame_start) begin
                    load_screen_d = target;
                    load_req_d    = 1'b1;
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_ack) begin
                    screen_d   = load_screen_q;
                    load_req_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                load_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            step_q        <= '0;
            screen_q      <= '0;
            load_screen_q <= '0;
            load_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            screen_q      <= screen_d;
            load_screen_q <= load_screen_d;
            load_req_q    <= load_req_d;
        end
    end

    assign load_req    = load_req_q;
    assign load_screen = load_screen_q;
    assign screen      = screen_q;
    assign busy        = (state_q != S_IDLE);

endmodule
